// File: rtl/prog_clk_div_if.sv
// Ratio-update handshake between the control stage and prog_clk_div.
// The ratio width defaults to the DATA_WIDTH macro, or 8 if DATA_WIDTH is not defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface prog_clk_div_if #(
  parameter int WIDTH = `DATA_WIDTH
);
  logic [WIDTH-1:0] div_ratio;
  logic             ratio_valid;
  logic             ratio_ready;

  modport master (output div_ratio, output ratio_valid, input ratio_ready);
  modport slave  (input div_ratio, input ratio_valid, output ratio_ready);
endinterface

// File: rtl/prog_clk_div.sv
// Programmable glitch-free divider: clk_out = clk / (2*N). New ratios take effect only at the
// high-to-low period boundary. Optional PROG_CLK_DIV_PERIOD_CNT_EN adds the period_count output.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module prog_clk_div #(
  parameter int WIDTH = `DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  prog_clk_div_if.slave    rif,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] active_ratio
`ifdef PROG_CLK_DIV_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_count
`endif
);

  localparam logic [1:0] ST_STOPPED  = 2'd0;
  localparam logic [1:0] ST_RUN_LOW  = 2'd1;
  localparam logic [1:0] ST_RUN_HIGH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             running_q;
  logic             at_end;
  logic             accept;
  logic             apply;

  assign rif.ratio_ready = !pend_full_q;
  assign accept          = rif.ratio_valid && !pend_full_q;
  assign at_end          = (cnt_q == active_q - WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    clk_out_d   = clk_out_q;
    tick_d      = 1'b0;
    apply       = 1'b0;

    case (state_q)
      ST_STOPPED: begin
        clk_out_d = 1'b0;
        cnt_d     = '0;
        apply     = pend_full_q;
      end
      ST_RUN_LOW: begin
        if (at_end) begin
          cnt_d     = '0;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
          state_d   = ST_RUN_HIGH;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      ST_RUN_HIGH: begin
        if (at_end) begin
          cnt_d     = '0;
          clk_out_d = 1'b0;
          state_d   = ST_RUN_LOW;
          apply     = pend_full_q;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: begin
        state_d   = ST_STOPPED;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase

    // Apply and accept are mutually exclusive: accept needs an empty pending slot.
    if (apply) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
      cnt_d       = '0;
      state_d     = (pend_q != '0) ? ST_RUN_LOW : ST_STOPPED;
    end else if (accept) begin
      pend_d      = rif.div_ratio;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_STOPPED;
      cnt_q       <= '0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      running_q   <= (active_d != '0);
    end
  end

  assign clk_out      = clk_out_q;
  assign tick         = tick_q;
  assign running      = running_q;
  assign active_ratio = active_q;

`ifdef PROG_CLK_DIV_PERIOD_CNT_EN
  logic [15:0] pcnt_q, pcnt_d;
  logic        boundary;

  assign boundary = (state_q == ST_RUN_HIGH) && at_end;

  // A ratio apply restarts the count even when it lands on a boundary.
  always_comb begin
    pcnt_d = pcnt_q;
    if (apply)         pcnt_d = '0;
    else if (boundary) pcnt_d = pcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

  assign period_count = pcnt_q;
`endif

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div: period-position model compared every cycle,
// plus directed phase-length and handshake checks with hand-computed values.
`timescale 1ns/1ps

module tb_prog_clk_div;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clk_out, tick, running;
  logic [W-1:0] active_ratio;
`ifdef PROG_CLK_DIV_PERIOD_CNT_EN
  logic [15:0]  period_count;
`endif

  int n_vec = 0;
  int n_bad = 0;

  prog_clk_div_if #(.WIDTH(W)) rif ();

  prog_clk_div #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .rif          (rif),
    .clk_out      (clk_out),
    .tick         (tick),
    .running      (running),
    .active_ratio (active_ratio)
`ifdef PROG_CLK_DIV_PERIOD_CNT_EN
    ,
    .period_count (period_count)
`endif
  );

  always #5 clk = ~clk;

  // Model: a running divider is described by its ratio and the position within the 2N period.
  int m_n = 0, m_pos = 0, m_pend = 0, m_pc = 0;
  bit m_stop = 1'b1, m_pf = 1'b0, m_live = 1'b0;

  always @(posedge clk) begin
    bit acc, applied;
    int acc_v;
    if (reset) begin
      m_n = 0; m_pos = 0; m_stop = 1'b1; m_pf = 1'b0; m_pend = 0; m_pc = 0; m_live = 1'b1;
    end else begin
      acc     = rif.ratio_valid && !m_pf;
      acc_v   = int'(rif.div_ratio);
      applied = 1'b0;
      if (m_stop) begin
        applied = m_pf;
      end else if (m_pos == 2 * m_n - 1) begin
        m_pos   = 0;
        m_pc    = (m_pc + 1) % 65536;
        applied = m_pf;
      end else begin
        m_pos++;
      end
      if (applied) begin
        m_n = m_pend; m_pf = 1'b0; m_stop = (m_pend == 0); m_pos = 0; m_pc = 0;
      end
      if (acc) begin
        m_pend = acc_v; m_pf = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (m_live) begin
      n_vec++;
      chk("clk_out", int'(clk_out), int'(!m_stop && m_pos >= m_n));
      chk("tick", int'(tick), int'(!m_stop && m_pos == m_n));
      chk("running", int'(running), int'(m_n != 0));
      chk("active_ratio", int'(active_ratio), m_n);
      chk("ratio_ready", int'(rif.ratio_ready), int'(!m_pf));
`ifdef PROG_CLK_DIV_PERIOD_CNT_EN
      chk("period_count", int'(period_count), m_pc);
`endif
    end
  end

  task automatic hchk(input string name, input int act, input int exp);
    n_vec++;
    chk(name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input int v);
    rif.div_ratio   = W'(v);
    rif.ratio_valid = 1'b1;
    @(negedge clk);
    rif.ratio_valid = 1'b0;
  endtask

  task automatic wait_active(input int v, input int limit);
    int i = 0;
    while (int'(active_ratio) != v && i < limit) begin @(negedge clk); i++; end
    if (int'(active_ratio) != v) begin
      n_bad++;
      $display("FAIL wait_active timeout: got %0d, expected %0d", active_ratio, v);
    end
  endtask

  task automatic wait_tick(input int limit);
    int i = 0;
    while (!tick && i < limit) begin @(negedge clk); i++; end
    if (!tick) begin
      n_bad++;
      $display("FAIL wait_tick timeout: got tick=0, expected 1 within %0d cycles", limit);
    end
  endtask

  task automatic measure(input logic lvl, output int len);
    len = 0;
    while (clk_out == lvl && len < 1000) begin len++; @(negedge clk); end
  endtask

  initial begin
    int len;
    rif.div_ratio   = '0;
    rif.ratio_valid = 1'b0;
    cyc(2);
    reset = 1'b0;
    hchk("reset clk_out", int'(clk_out), 0);
    hchk("reset tick", int'(tick), 0);
    hchk("reset running", int'(running), 0);
    hchk("reset active_ratio", int'(active_ratio), 0);
    hchk("reset ratio_ready", int'(rif.ratio_ready), 1);
    cyc(3);

    // Start from STOPPED with N=3.
    write(3);
    hchk("start ready low", int'(rif.ratio_ready), 0);
    cyc(1);
    hchk("start applied", int'(active_ratio), 3);
    hchk("start ready back", int'(rif.ratio_ready), 1);
    measure(1'b0, len); hchk("N3 first low", len, 3);
    measure(1'b1, len); hchk("N3 high", len, 3);
    cyc(12);

    // N=1, then max ratio.
    write(1);
    wait_active(1, 20);
    cyc(10);
    write(255);
    wait_active(255, 20);
    wait_tick(600);
    measure(1'b1, len); hchk("N255 high", len, 255);
    measure(1'b0, len); hchk("N255 low", len, 255);

    // Glitch-free change 4 -> 2 during the high phase; a second write is ignored.
    write(4);
    wait_active(4, 1000);
    wait_tick(20);
    cyc(1);
    rif.div_ratio = 8'd2; rif.ratio_valid = 1'b1;
    @(negedge clk);
    rif.div_ratio = 8'd7;
    @(negedge clk);
    rif.ratio_valid = 1'b0;
    hchk("N4 still high", int'(clk_out), 1);
    wait_active(2, 10);
    measure(1'b0, len); hchk("N2 low after change", len, 2);
    measure(1'b1, len); hchk("N2 high after change", len, 2);
    hchk("ignored write", int'(active_ratio), 2);

    // Stop and restart.
    write(5);
    wait_active(5, 20);
    cyc(7);
    write(0);
    wait_active(0, 30);
    cyc(5);
    hchk("stopped running", int'(running), 0);
    hchk("stopped clk_out", int'(clk_out), 0);
    write(2);
    wait_tick(10);
    measure(1'b1, len); hchk("restart high", len, 2);
    measure(1'b0, len); hchk("restart low", len, 2);

    // Accept on the boundary edge: applied one period later.
    wait_tick(10);
    @(negedge clk);
    write(3);
    hchk("collision not applied", int'(active_ratio), 2);
    hchk("collision pending", int'(rif.ratio_ready), 0);
    measure(1'b0, len); hchk("collision old low", len, 2);
    measure(1'b1, len); hchk("collision old high", len, 2);
    hchk("collision applied", int'(active_ratio), 3);
`ifdef PROG_CLK_DIV_PERIOD_CNT_EN
    hchk("period_count after apply", int'(period_count), 0);
    cyc(18);
    hchk("period_count three periods", int'(period_count), 3);
`endif

    // Reset during the high phase discards a pending ratio.
    wait_tick(20);
    write(6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hchk("midreset clk_out", int'(clk_out), 0);
    hchk("midreset ready", int'(rif.ratio_ready), 1);
    hchk("midreset active", int'(active_ratio), 0);
    cyc(8);
    hchk("midreset pending dropped", int'(running), 0);
    write(2);
    cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
